// File: rtl/div_pkg.sv
// Shared opcodes, FSM encoding and the most-negative-value helper for the
// iterative divider.
package div_pkg;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam int MAX_DW = 64;

  // Most-negative two's-complement value for a dw-bit word, zero-extended.
  function automatic logic [MAX_DW-1:0] min_neg(input int dw);
    logic [MAX_DW-1:0] one;
    one = {{(MAX_DW-1){1'b0}}, 1'b1};
    return one << (dw - 1);
  endfunction

endpackage

// File: rtl/div_sign_fix.sv
// Applies the signed-result correction to a raw unsigned quotient/remainder
// pair and selects the one the opcode asks for.
module div_sign_fix
  import div_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic [DW-1:0] quo,
  input  logic [DW-1:0] rem,
  input  logic          neg_dividend,
  input  logic          neg_divisor,
  input  logic [1:0]    op,
  output logic [DW-1:0] result
);

  logic          signed_op;
  logic [DW-1:0] quo_fix;
  logic [DW-1:0] rem_fix;

  assign signed_op = ~op[0];
  // Quotient sign follows operand-sign disagreement; remainder follows dividend.
  assign quo_fix = (signed_op & (neg_dividend ^ neg_divisor)) ? -quo : quo;
  assign rem_fix = (signed_op & neg_dividend) ? -rem : rem;
  assign result  = op[1] ? rem_fix : quo_fix;

endmodule

// File: rtl/div_iter_unit.sv
// Restoring radix-2 divider for DIV/DIVU/REM/REMU: one quotient bit per clock,
// with a single-cycle path for divide-by-zero and signed overflow.
module div_iter_unit
  import div_pkg::*;
#(
  parameter int DW = 32,
  parameter int TW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start_i,
  input  logic [1:0]    op_i,
  input  logic [DW-1:0] dividend_i,
  input  logic [DW-1:0] divisor_i,
  input  logic [TW-1:0] tag_i,
  input  logic          kill_i,
  output logic          ready_o,
  output logic          busy_o,
  output logic          valid_o,
  output logic [DW-1:0] result_o,
  output logic [TW-1:0] tag_o
);

  localparam int CW = $clog2(DW) + 1;
  localparam logic [MAX_DW-1:0] MIN_FULL = min_neg(DW);
  localparam logic [DW-1:0]     MIN_VAL  = MIN_FULL[DW-1:0];

  state_t        state;
  logic [1:0]    op_reg;
  logic [TW-1:0] tag_reg;
  logic          neg_a_reg;
  logic          neg_b_reg;
  logic [DW-1:0] quo_reg;
  logic [DW-1:0] dvs_reg;
  logic [DW-1:0] rem_reg;
  logic [CW-1:0] cnt_reg;

  logic          signed_op;
  logic          neg_a;
  logic          neg_b;
  logic [DW-1:0] abs_a;
  logic [DW-1:0] abs_b;
  logic          div_zero;
  logic          overflow;
  logic [DW-1:0] fast_res;
  logic [DW:0]   rem_shift;
  logic [DW:0]   trial;
  logic [DW-1:0] fix_res;

  assign ready_o = (state == ST_IDLE) || (state == ST_DONE);
  assign busy_o  = (state == ST_CALC) || (state == ST_FIX);
  assign valid_o = (state == ST_DONE);

  assign signed_op = ~op_i[0];
  assign neg_a     = signed_op & dividend_i[DW-1];
  assign neg_b     = signed_op & divisor_i[DW-1];
  assign abs_a     = neg_a ? -dividend_i : dividend_i;
  assign abs_b     = neg_b ? -divisor_i : divisor_i;
  assign div_zero  = (divisor_i == '0);
  assign overflow  = signed_op && (dividend_i == MIN_VAL) && (divisor_i == '1);
  assign fast_res  = div_zero ? (op_i[1] ? dividend_i : '1)
                              : (op_i[1] ? '0 : dividend_i);

  // The stored remainder is always below the divisor, so DW bits hold it;
  // only the shifted value needs the extra bit.
  assign rem_shift = {rem_reg, quo_reg[DW-1]};
  assign trial     = rem_shift - {1'b0, dvs_reg};

  div_sign_fix #(.DW(DW)) u_sign_fix (
    .quo          (quo_reg),
    .rem          (rem_reg),
    .neg_dividend (neg_a_reg),
    .neg_divisor  (neg_b_reg),
    .op           (op_reg),
    .result       (fix_res)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      op_reg    <= '0;
      tag_reg   <= '0;
      neg_a_reg <= 1'b0;
      neg_b_reg <= 1'b0;
      quo_reg   <= '0;
      dvs_reg   <= '0;
      rem_reg   <= '0;
      cnt_reg   <= '0;
      result_o  <= '0;
      tag_o     <= '0;
    end else if (kill_i) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start_i) begin
            op_reg    <= op_i;
            tag_reg   <= tag_i;
            neg_a_reg <= neg_a;
            neg_b_reg <= neg_b;
            quo_reg   <= abs_a;
            dvs_reg   <= abs_b;
            rem_reg   <= '0;
            cnt_reg   <= '0;
            if (div_zero || overflow) begin
              result_o <= fast_res;
              tag_o    <= tag_i;
              state    <= ST_DONE;
            end else begin
              state <= ST_CALC;
            end
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_CALC: begin
          // quo_reg shifts dividend bits out the top and quotient bits in the bottom.
          if (!trial[DW]) begin
            rem_reg <= trial[DW-1:0];
            quo_reg <= {quo_reg[DW-2:0], 1'b1};
          end else begin
            rem_reg <= rem_shift[DW-1:0];
            quo_reg <= {quo_reg[DW-2:0], 1'b0};
          end
          cnt_reg <= cnt_reg + 1'b1;
          if (cnt_reg == CW'(DW - 1)) begin
            state <= ST_FIX;
          end
        end
        ST_FIX: begin
          result_o <= fix_res;
          tag_o    <= tag_reg;
          state    <= ST_DONE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_iter_unit.sv
// Directed-vector bench for div_iter_unit (DW=32): results, latency, fast
// paths, kill, back-to-back issue and asynchronous reset.
module tb_div_iter_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_i = 1'b0;
  logic [1:0]  op_i = 2'b00;
  logic [31:0] dividend_i = '0;
  logic [31:0] divisor_i = '0;
  logic [4:0]  tag_i = '0;
  logic        kill_i = 1'b0;
  logic        ready_o;
  logic        busy_o;
  logic        valid_o;
  logic [31:0] result_o;
  logic [4:0]  tag_o;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  div_iter_unit #(.DW(32), .TW(5)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (start_i),
    .op_i       (op_i),
    .dividend_i (dividend_i),
    .divisor_i  (divisor_i),
    .tag_i      (tag_i),
    .kill_i     (kill_i),
    .ready_o    (ready_o),
    .busy_o     (busy_o),
    .valid_o    (valid_o),
    .result_o   (result_o),
    .tag_o      (tag_o)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  // Issue one op at the next edge and wait (bounded) for its valid_o.
  task automatic run(input string name, input logic [1:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic [4:0] t,
                     input logic [31:0] exp, input int exp_lat);
    int   lat;
    logic bz;
    @(negedge clk);
    start_i = 1'b1; op_i = op; dividend_i = a; divisor_i = b; tag_i = t;
    @(posedge clk); #1;
    start_i = 1'b0;
    bz  = busy_o;
    lat = 1;
    while (!valid_o && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    $display("%s op=%0d a=0x%08h b=0x%08h -> result=0x%08h tag=%0d lat=%0d",
             name, op, a, b, result_o, tag_o, lat);
    chk({name, "_res"}, result_o, exp);
    chk({name, "_tag"}, 32'(tag_o), 32'(t));
    chk({name, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({name, "_busy"}, 32'(bz), 32'(exp_lat != 1));
  endtask

  // Watch a window of cycles and count any valid_o pulses.
  task automatic no_valid(input string name, input int cycles);
    int seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (valid_o) seen++;
    end
    chk(name, 32'(seen), 32'd0);
  endtask

  initial begin
    int lat;
    #2;
    chk("rst_ready", 32'(ready_o), 32'd1);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_result", result_o, 32'd0);
    chk("rst_tag", 32'(tag_o), 32'd0);
    @(negedge clk); rst_n = 1'b1;

    run("divu_100_7", 2'b01, 32'd100, 32'd7, 5'd3, 32'd14, 34);
    run("remu_100_7", 2'b11, 32'd100, 32'd7, 5'd4, 32'd2, 34);
    run("div_m7_2",   2'b00, 32'hFFFF_FFF9, 32'd2, 5'd5, 32'hFFFF_FFFD, 34);
    run("rem_m7_2",   2'b10, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'hFFFF_FFFF, 34);
    run("rem_7_m2",   2'b10, 32'd7, 32'hFFFF_FFFE, 5'd7, 32'd1, 34);
    run("div_min_2",  2'b00, 32'h8000_0000, 32'd2, 5'd8, 32'hC000_0000, 34);
    run("div_5_0",    2'b00, 32'd5, 32'd0, 5'd9, 32'hFFFF_FFFF, 1);
    run("remu_5_0",   2'b11, 32'd5, 32'd0, 5'd10, 32'd5, 1);
    run("div_ovf",    2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h8000_0000, 1);
    run("rem_ovf",    2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'd0, 1);
    run("divu_ovf",   2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'd0, 34);

    // Kill in the 10th CALC cycle.
    @(negedge clk);
    start_i = 1'b1; op_i = 2'b01; dividend_i = 32'd1000; divisor_i = 32'd3; tag_i = 5'd14;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk); kill_i = 1'b1;
    @(posedge clk); #1;
    kill_i = 1'b0;
    $display("kill_calc ready=%0d busy=%0d valid=%0d", ready_o, busy_o, valid_o);
    chk("kill_ready", 32'(ready_o), 32'd1);
    chk("kill_busy", 32'(busy_o), 32'd0);
    no_valid("kill_no_valid", 40);
    run("divu_9_3", 2'b01, 32'd9, 32'd3, 5'd15, 32'd3, 34);

    // start and kill together in IDLE: nothing accepted.
    @(negedge clk);
    start_i = 1'b1; kill_i = 1'b1; op_i = 2'b01; dividend_i = 32'd50; divisor_i = 32'd5;
    @(posedge clk); #1;
    start_i = 1'b0; kill_i = 1'b0;
    $display("start_kill busy=%0d ready=%0d", busy_o, ready_o);
    chk("startkill_busy", 32'(busy_o), 32'd0);
    no_valid("startkill_no_valid", 40);

    // Back-to-back: start held through the first op's DONE cycle.
    @(negedge clk);
    start_i = 1'b1; op_i = 2'b01; dividend_i = 32'd100; divisor_i = 32'd7; tag_i = 5'd16;
    @(posedge clk); #1;
    op_i = 2'b11; dividend_i = 32'd1000; divisor_i = 32'd9; tag_i = 5'd17;
    lat = 1;
    while (!valid_o && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    $display("b2b_first result=0x%08h tag=%0d lat=%0d", result_o, tag_o, lat);
    chk("b2b1_res", result_o, 32'd14);
    chk("b2b1_tag", 32'(tag_o), 32'd16);
    chk("b2b1_lat", 32'(lat), 32'd34);
    @(posedge clk); #1;
    start_i = 1'b0;
    chk("b2b_no_gap", 32'(busy_o), 32'd1);
    lat = 1;
    while (!valid_o && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    $display("b2b_second result=0x%08h tag=%0d lat=%0d", result_o, tag_o, lat);
    chk("b2b2_res", result_o, 32'd1);
    chk("b2b2_tag", 32'(tag_o), 32'd17);
    chk("b2b2_lat", 32'(lat), 32'd34);

    // Asynchronous reset in the middle of CALC.
    @(negedge clk);
    start_i = 1'b1; op_i = 2'b01; dividend_i = 32'd77; divisor_i = 32'd5; tag_i = 5'd18;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    $display("mid_reset ready=%0d busy=%0d valid=%0d result=0x%08h tag=%0d",
             ready_o, busy_o, valid_o, result_o, tag_o);
    chk("mrst_ready", 32'(ready_o), 32'd1);
    chk("mrst_busy", 32'(busy_o), 32'd0);
    chk("mrst_result", result_o, 32'd0);
    chk("mrst_tag", 32'(tag_o), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    no_valid("mrst_no_valid", 40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
